// File: rtl/enc_parity_stream_if.sv
// Handshake bundle for enc_parity_stream: input word channel, codeword channel
// and accepted-word counter.
interface enc_parity_stream_if #(
   parameter int AMBA_WORD = 32,
   parameter int CNT_WIDTH = 16
);
   logic                         in_valid;
   logic                         in_ready;
   logic [1:0]                   codeword_width;
   logic [AMBA_WORD-1:0]         data_in;
   logic                         inj_en;
   logic [$clog2(AMBA_WORD)-1:0] inj_pos;
   logic                         out_valid;
   logic                         out_ready;
   logic [AMBA_WORD-1:0]         data_out;
   logic [1:0]                   out_width;
   logic [CNT_WIDTH-1:0]         word_cnt;

   modport master (
      output in_valid, codeword_width, data_in, inj_en, inj_pos, out_ready,
      input  in_ready, out_valid, data_out, out_width, word_cnt
   );

   modport slave (
      input  in_valid, codeword_width, data_in, inj_en, inj_pos, out_ready,
      output in_ready, out_valid, data_out, out_width, word_cnt
   );
endinterface

// File: rtl/enc_parity_stream.sv
// Registered Hamming SECDED encoder with valid/ready on both sides, a 2-entry
// output buffer, 8/16/32/64-bit codeword modes and single-bit error injection.
module enc_parity_stream #(
   parameter int AMBA_WORD = 32,
   parameter int CNT_WIDTH = 16
) (
   input logic                clk,
   input logic                rst,
   enc_parity_stream_if.slave bus
);

   typedef struct packed {
      logic [1:0]           mode;
      logic [AMBA_WORD-1:0] cw;
   } entry_t;

   // The 64-bit mode only exists on a 64-bit bus; otherwise it degrades to mode 00.
   function automatic logic [1:0] eff_mode(input logic [1:0] m);
      if (AMBA_WORD == 32 && m == 2'b11) return 2'b00;
      return m;
   endfunction

   function automatic int cw_bits(input logic [1:0] m);
      case (m)
         2'b00:   return 8;
         2'b01:   return 16;
         2'b10:   return 32;
         default: return 64;
      endcase
   endfunction

   function automatic logic [AMBA_WORD-1:0] encode(input logic [63:0] d, input logic [1:0] m,
                                                   input logic inj, input int ipos);
      int          n;
      int          np;
      int          k;
      logic [5:0]  di;
      logic [6:0]  par;
      logic        ovl;
      logic [63:0] cw;
      n   = cw_bits(m);
      np  = $clog2(n) + 1;
      k   = n - np;
      di  = 6'd0;
      par = '0;
      ovl = 1'b0;
      // Walk the Hamming positions; non-powers of two carry data bits in order.
      for (int pos = 1; pos < 64; pos++) begin
         if (pos < n && (pos & (pos - 1)) != 0) begin
            for (int j = 0; j < 6; j++) begin
               if (j < np - 1 && ((pos >> j) & 1) == 1) par = par ^ (7'(d[di]) << j);
            end
            ovl = ovl ^ d[di];
            di  = di + 6'd1;
         end
      end
      par = par | (7'(ovl ^ (^par)) << (np - 1));
      cw  = (d & ((64'd1 << k) - 64'd1)) | (64'(par) << k);
      if (inj && ipos < n) cw = cw ^ (64'd1 << ipos);
      return AMBA_WORD'(cw);
   endfunction

   entry_t               head_q, head_d;
   entry_t               tail_q, tail_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
   entry_t               new_e;
   logic                 push;
   logic                 pop;

   assign push = bus.in_valid && (cnt_q != 2'd2);
   assign pop  = (cnt_q != 2'd0) && bus.out_ready;

   always_comb begin
      new_e.mode = eff_mode(bus.codeword_width);
      new_e.cw   = encode(64'(bus.data_in), new_e.mode, bus.inj_en, int'(bus.inj_pos));
   end

   // Head is the visible entry; it only changes on a refill, so an empty buffer
   // keeps showing the last codeword.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      wcnt_d = wcnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = new_e;
            else               tail_d = new_e;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            if (cnt_q == 2'd2) head_d = tail_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11:   head_d = new_e;
         default: ;
      endcase
      if (push && wcnt_q != {CNT_WIDTH{1'b1}}) wcnt_d = wcnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         cnt_q  <= 2'd0;
         wcnt_q <= '0;
      end else begin
         head_q <= head_d;
         cnt_q  <= cnt_d;
         wcnt_q <= wcnt_d;
      end
   end

   always_ff @(posedge clk) begin
      tail_q <= tail_d;
   end

   assign bus.in_ready  = (cnt_q != 2'd2);
   assign bus.out_valid = (cnt_q != 2'd0);
   assign bus.data_out  = head_q.cw;
   assign bus.out_width = head_q.mode;
   assign bus.word_cnt  = wcnt_q;

endmodule

// File: tb/tb_enc_parity_stream.sv
// Scoreboard bench for enc_parity_stream: a 32-bit and a 64-bit instance driven
// with directed words, back-pressure, injection, reset and random traffic.
module tb_enc_parity_stream;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   enc_parity_stream_if #(.AMBA_WORD(32), .CNT_WIDTH(16)) b32 ();
   enc_parity_stream_if #(.AMBA_WORD(64), .CNT_WIDTH(16)) b64 ();

   enc_parity_stream #(.AMBA_WORD(32), .CNT_WIDTH(16)) u32 (.clk(clk), .rst(rst), .bus(b32));
   enc_parity_stream #(.AMBA_WORD(64), .CNT_WIDTH(16)) u64 (.clk(clk), .rst(rst), .bus(b64));

   int          n_checks = 0;
   int          n_fail   = 0;
   int          pushes32 = 0;
   int          pushes64 = 0;
   logic [65:0] q32[$];
   logic [65:0] q64[$];

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference encoder: builds the Hamming position array, then packs it.
   function automatic logic [65:0] ref_model(input logic [63:0] d, input logic [1:0] m,
                                             input int aw, input logic inj, input int ipos);
      int          n, p, k, di;
      logic        h[64];
      logic [6:0]  par;
      logic [63:0] cw;
      logic [1:0]  me;
      me = (aw == 32 && m == 2'b11) ? 2'b00 : m;
      case (me)
         2'b00:   begin n = 8;  p = 4; end
         2'b01:   begin n = 16; p = 5; end
         2'b10:   begin n = 32; p = 6; end
         default: begin n = 64; p = 7; end
      endcase
      k  = n - p;
      di = 0;
      for (int i = 0; i < 64; i++) h[i] = 1'b0;
      for (int pos = 1; pos < n; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            h[pos] = d[di];
            di++;
         end
      end
      par = '0;
      for (int j = 0; j < p - 1; j++) begin
         for (int pos = 1; pos < n; pos++)
            if (((pos >> j) & 1) == 1 && (pos & (pos - 1)) != 0) par[j] = par[j] ^ h[pos];
         h[1 << j] = par[j];
      end
      for (int pos = 1; pos < n; pos++) par[p-1] = par[p-1] ^ h[pos];
      cw = '0;
      for (int i = 0; i < k; i++) cw[i] = d[i];
      for (int j = 0; j < p; j++) cw[k+j] = par[j];
      if (inj && ipos < n) cw[ipos] = ~cw[ipos];
      return {me, cw};
   endfunction

   task automatic tick();
      logic [65:0] e;
      if (!rst) begin
         if (b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) chk("sb32_unexpected", 66'(q32.size()), 66'(1));
            else begin
               e = q32.pop_front();
               chk("sb32_out", {b32.out_width, 32'h0, b32.data_out}, e);
            end
         end
         if (b32.in_valid && b32.in_ready) begin
            q32.push_back(ref_model(64'(b32.data_in), b32.codeword_width, 32, b32.inj_en, int'(b32.inj_pos)));
            pushes32++;
         end
         if (b64.out_valid && b64.out_ready) begin
            if (q64.size() == 0) chk("sb64_unexpected", 66'(q64.size()), 66'(1));
            else begin
               e = q64.pop_front();
               chk("sb64_out", {b64.out_width, b64.data_out}, e);
            end
         end
         if (b64.in_valid && b64.in_ready) begin
            q64.push_back(ref_model(b64.data_in, b64.codeword_width, 64, b64.inj_en, int'(b64.inj_pos)));
            pushes64++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send32(input logic [31:0] d, input logic [1:0] m, input logic ie, input logic [4:0] ip);
      int w;
      w = 0;
      b32.data_in = d; b32.codeword_width = m; b32.inj_en = ie; b32.inj_pos = ip;
      b32.in_valid = 1'b1;
      while (!b32.in_ready && w < 20) begin tick(); w++; end
      if (!b32.in_ready) chk("send32_timeout", 66'(b32.in_ready), 66'(1));
      tick();
      b32.in_valid = 1'b0;
      b32.inj_en   = 1'b0;
   endtask

   task automatic send64(input logic [63:0] d, input logic [1:0] m);
      int w;
      w = 0;
      b64.data_in = d; b64.codeword_width = m; b64.inj_en = 1'b0; b64.inj_pos = '0;
      b64.in_valid = 1'b1;
      while (!b64.in_ready && w < 20) begin tick(); w++; end
      if (!b64.in_ready) chk("send64_timeout", 66'(b64.in_ready), 66'(1));
      tick();
      b64.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      b32.in_valid = 1'b0;
      b64.in_valid = 1'b0;
      tick();
      tick();
      q32.delete();
      q64.delete();
      pushes32 = 0;
      pushes64 = 0;
   endtask

   task automatic drain(input int budget);
      int w;
      w = 0;
      b32.in_valid = 1'b0; b64.in_valid = 1'b0;
      b32.out_ready = 1'b1; b64.out_ready = 1'b1;
      while ((q32.size() != 0 || q64.size() != 0) && w < budget) begin tick(); w++; end
      chk("drain32_empty", 66'(q32.size()), 66'(0));
      chk("drain64_empty", 66'(q64.size()), 66'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [65:0] e;
      b32.in_valid = 1'b0; b32.codeword_width = 2'b00; b32.data_in = '0;
      b32.inj_en = 1'b0; b32.inj_pos = '0; b32.out_ready = 1'b1;
      b64.in_valid = 1'b0; b64.codeword_width = 2'b00; b64.data_in = '0;
      b64.inj_en = 1'b0; b64.inj_pos = '0; b64.out_ready = 1'b1;
      rst = 1'b1;

      do_reset();
      chk("rst_in_ready",  66'(b32.in_ready),  66'(1));
      chk("rst_out_valid", 66'(b32.out_valid), 66'(0));
      chk("rst_data_out",  66'(b32.data_out),  66'(0));
      chk("rst_out_width", 66'(b32.out_width), 66'(0));
      chk("rst_word_cnt",  66'(b32.word_cnt),  66'(0));
      rst = 1'b0;

      // Mode 00 directed words, one-cycle latency
      send32(32'hB, 2'b00, 1'b0, 5'd0);
      chk("lat_valid", 66'(b32.out_valid), 66'(1));
      chk("m00_B",     66'(b32.data_out),  66'(32'h1B));
      chk("m00_width", 66'(b32.out_width), 66'(0));
      send32(32'hF, 2'b00, 1'b0, 5'd0);
      chk("m00_F", 66'(b32.data_out), 66'(32'hFF));
      send32(32'h0, 2'b00, 1'b0, 5'd0);
      chk("m00_0", 66'(b32.data_out), 66'(32'h00));
      send32(32'hFFFF_FFFB, 2'b00, 1'b0, 5'd0);
      chk("m00_junk", 66'(b32.data_out), 66'(32'h1B));

      // Modes 01/10 all ones with junk above the data width
      send32(32'hFFFF_FFFF, 2'b01, 1'b0, 5'd0);
      chk("m01_ones",  66'(b32.data_out),  66'(32'h0000_FFFF));
      chk("m01_width", 66'(b32.out_width), 66'(1));
      send32(32'hFFFF_FFFF, 2'b10, 1'b0, 5'd0);
      chk("m10_ones",  66'(b32.data_out),  66'(32'hFFFF_FFFF));
      chk("m10_width", 66'(b32.out_width), 66'(2));

      // Mode 11 on a 32-bit bus falls back to mode 00
      send32(32'hB, 2'b11, 1'b0, 5'd0);
      chk("m11_32_data",  66'(b32.data_out),  66'(32'h1B));
      chk("m11_32_width", 66'(b32.out_width), 66'(0));

      // Injection
      send32(32'hB, 2'b00, 1'b1, 5'd7);
      chk("inj_pos7", 66'(b32.data_out), 66'(32'h9B));
      send32(32'hB, 2'b00, 1'b1, 5'd12);
      chk("inj_pos12", 66'(b32.data_out), 66'(32'h1B));
      tick();

      // Back-pressure
      b32.out_ready = 1'b0;
      send32(32'h3, 2'b00, 1'b0, 5'd0);
      send32(32'h5, 2'b00, 1'b0, 5'd0);
      chk("bp_full_ready", 66'(b32.in_ready), 66'(0));
      b32.data_in = 32'h6; b32.codeword_width = 2'b00; b32.in_valid = 1'b1;
      tick(); tick(); tick();
      e = ref_model(64'h3, 2'b00, 32, 1'b0, 0);
      chk("bp_hold_data",  66'(b32.data_out), 66'(e[31:0]));
      chk("bp_still_full", 66'(b32.in_ready), 66'(0));
      chk("bp_word_cnt",   66'(b32.word_cnt), 66'(pushes32));
      b32.out_ready = 1'b1;
      tick();
      chk("bp_ready_after_pop", 66'(b32.in_ready), 66'(1));
      tick();
      b32.in_valid = 1'b0;
      drain(10);
      chk("wc32_after_bp", 66'(b32.word_cnt), 66'(pushes32));

      // Reset with two words buffered
      b32.out_ready = 1'b0;
      send32(32'h1, 2'b01, 1'b0, 5'd0);
      send32(32'h2, 2'b10, 1'b0, 5'd0);
      rst = 1'b1;
      tick();
      chk("mid_rst_out_valid", 66'(b32.out_valid), 66'(0));
      chk("mid_rst_in_ready",  66'(b32.in_ready),  66'(1));
      chk("mid_rst_word_cnt",  66'(b32.word_cnt),  66'(0));
      q32.delete(); q64.delete();
      pushes32 = 0; pushes64 = 0;
      rst = 1'b0;
      b32.out_ready = 1'b1;

      // 64-bit instance
      send64(64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
      chk("m11_64_data",  66'(b64.data_out),  66'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("m11_64_width", 66'(b64.out_width), 66'(3));
      send64(64'hB, 2'b00);
      chk("m00_64_data", 66'(b64.data_out), 66'(64'h1B));

      // Random traffic on both instances
      for (int c = 0; c < 400; c++) begin
         b32.in_valid       = ($urandom_range(0, 3) != 0);
         b32.data_in        = $urandom;
         b32.codeword_width = 2'($urandom_range(0, 3));
         b32.inj_en         = ($urandom_range(0, 3) == 0);
         b32.inj_pos        = 5'($urandom_range(0, 31));
         b32.out_ready      = ($urandom_range(0, 3) != 0);
         b64.in_valid       = ($urandom_range(0, 2) != 0);
         b64.data_in        = {$urandom, $urandom};
         b64.codeword_width = 2'($urandom_range(0, 3));
         b64.inj_en         = ($urandom_range(0, 3) == 0);
         b64.inj_pos        = 6'($urandom_range(0, 63));
         b64.out_ready      = ($urandom_range(0, 2) != 0);
         tick();
      end
      drain(10);
      chk("wc32_random", 66'(b32.word_cnt), 66'(pushes32));
      chk("wc64_random", 66'(b64.word_cnt), 66'(pushes64));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
